// File: rtl/buffer_nxn_fpga_to_hps_pkg.sv
// Shared constants and state encoding for the FPGA-to-HPS result buffer.
package buffer_pkg;

  localparam int DEF_ELEM_W     = 8;
  localparam int DEF_MAX_DIM    = 5;
  localparam int DEF_WORD_W     = 32;
  localparam int DEF_TOTAL_W    = DEF_MAX_DIM * DEF_MAX_DIM * DEF_ELEM_W;
  localparam int DEF_NWORDS_MAX = (DEF_TOTAL_W + DEF_WORD_W - 1) / DEF_WORD_W;
  localparam int MIN_DIM        = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PACK = 2'd1,
    SEND = 2'd2
  } state_e;

  // Words needed to carry an n x n matrix of elem_w-bit elements.
  function automatic int words_for(input int n, input int elem_w, input int word_w);
    return (n * n * elem_w + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/buffer_nxn_fpga_to_hps_pack.sv
// Combinational repack of a padded MAX_DIM x MAX_DIM matrix into a dense N x N
// row-major vector; unused trailing elements are zero.
module matrix_nxn_pack
  import buffer_pkg::*;
#(
  parameter  int ELEM_W  = DEF_ELEM_W,
  parameter  int MAX_DIM = DEF_MAX_DIM,
  localparam int TOTAL_W = MAX_DIM * MAX_DIM * ELEM_W,
  localparam int SIZE_W  = $clog2(MAX_DIM + 1)
) (
  input  logic [TOTAL_W-1:0] matrix_i,
  input  logic [SIZE_W-1:0]  size_i,
  output logic [TOTAL_W-1:0] packed_o
);

  // Dense slot d holds source element (d / N, d % N) when d < N*N.
  for (genvar d = 0; d < MAX_DIM * MAX_DIM; d++) begin : g_elem
    logic [ELEM_W-1:0] elem;

    always_comb begin
      elem = '0;
      for (int n = MIN_DIM; n <= MAX_DIM; n++) begin
        if (size_i == SIZE_W'(n) && d < n * n)
          elem = matrix_i[TOTAL_W-1-((d / n) * MAX_DIM + d % n)*ELEM_W -: ELEM_W];
      end
    end

    assign packed_o[TOTAL_W-1-d*ELEM_W -: ELEM_W] = elem;
  end

endmodule

// File: rtl/buffer_nxn_fpga_to_hps.sv
// Captures one padded result matrix, repacks the active N x N block densely and
// streams it MSB-first as WORD_W-bit words over valid/ready with a last flag.
module buffer_nxn_fpga_to_hps
  import buffer_pkg::*;
#(
  parameter  int ELEM_W     = DEF_ELEM_W,
  parameter  int MAX_DIM    = DEF_MAX_DIM,
  parameter  int WORD_W     = DEF_WORD_W,
  localparam int TOTAL_W    = MAX_DIM * MAX_DIM * ELEM_W,
  localparam int NWORDS_MAX = (TOTAL_W + WORD_W - 1) / WORD_W,
  localparam int SIZE_W     = $clog2(MAX_DIM + 1),
  localparam int WC_W       = $clog2(NWORDS_MAX + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [TOTAL_W-1:0] matrix_in,
  input  logic [SIZE_W-1:0]  size_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  word_out,
  output logic               out_last,
  output logic [WC_W-1:0]    word_count,
  output logic [TOTAL_W-1:0] packed_out,
  output logic               size_err
);

  localparam int PAD_W = NWORDS_MAX * WORD_W;

  state_e             state_q, state_d;
  logic [TOTAL_W-1:0] mat_q, mat_d;
  logic [SIZE_W-1:0]  size_q, size_d;
  logic [TOTAL_W-1:0] packed_q, packed_d;
  logic [WC_W-1:0]    wc_q, wc_d;
  logic [WC_W-1:0]    idx_q, idx_d;
  logic               ov_q, ov_d;
  logic               ol_q, ol_d;
  logic [WORD_W-1:0]  wo_q, wo_d;
  logic               err_q, err_d;
  logic [TOTAL_W-1:0] pack_w;
  logic               size_ok;

  matrix_nxn_pack #(
    .ELEM_W  (ELEM_W),
    .MAX_DIM (MAX_DIM)
  ) u_pack (
    .matrix_i (mat_q),
    .size_i   (size_q),
    .packed_o (pack_w)
  );

  // Word k of the packed vector left-aligned in NWORDS_MAX words.
  function automatic logic [WORD_W-1:0] word_at(input logic [TOTAL_W-1:0] p,
                                                input logic [WC_W-1:0]    k);
    logic [PAD_W-1:0] padded;
    padded = PAD_W'(p) << (PAD_W - TOTAL_W);
    return padded[PAD_W-1-int'(k)*WORD_W -: WORD_W];
  endfunction

  assign size_ok = (size_in >= SIZE_W'(MIN_DIM)) && (size_in <= SIZE_W'(MAX_DIM));

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no branch leaves a value unassigned and no latch is inferred.
    state_d  = state_q;
    mat_d    = mat_q;
    size_d   = size_q;
    packed_d = packed_q;
    wc_d     = wc_q;
    idx_d    = idx_q;
    ov_d     = ov_q;
    ol_d     = ol_q;
    wo_d     = wo_q;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (size_ok) begin
            mat_d   = matrix_in;
            size_d  = size_in;
            state_d = PACK;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PACK: begin
        packed_d = pack_w;
        wc_d     = WC_W'(words_for(int'(size_q), ELEM_W, WORD_W));
        idx_d    = '0;
        wo_d     = word_at(pack_w, '0);
        ol_d     = (wc_d == WC_W'(1));
        ov_d     = 1'b1;
        state_d  = SEND;
      end
      SEND: begin
        if (out_ready) begin
          if (ol_q) begin
            ov_d    = 1'b0;
            ol_d    = 1'b0;
            wo_d    = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + WC_W'(1);
            wo_d  = word_at(packed_q, idx_d);
            ol_d  = (idx_d == wc_q - WC_W'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking <= so every register samples pre-edge values.
    if (!rst_n) begin
      state_q  <= IDLE;
      packed_q <= '0;
      wc_q     <= '0;
      idx_q    <= '0;
      ov_q     <= 1'b0;
      ol_q     <= 1'b0;
      wo_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      packed_q <= packed_d;
      wc_q     <= wc_d;
      idx_q    <= idx_d;
      ov_q     <= ov_d;
      ol_q     <= ol_d;
      wo_q     <= wo_d;
      err_q    <= err_d;
    end
  end

  // NOTE: the capture registers are not reset; they are only read in PACK, after a capture has loaded them.
  always_ff @(posedge clk) begin
    mat_q  <= mat_d;
    size_q <= size_d;
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = ov_q;
  assign out_last   = ol_q;
  assign word_out   = wo_q;
  assign word_count = wc_q;
  assign packed_out = packed_q;
  assign size_err   = err_q;

endmodule

// File: doc/buffer_nxn_fpga_to_hps.md
Name: buffer_nxn_fpga_to_hps

Overview:
Parametrised result-path buffer between the matrix datapath and the HPS bridge. It captures one MAX_DIM x MAX_DIM result matrix in padded row-major layout, for a runtime size N. It repacks the active NxN elements into a dense row-major vector and streams that vector to the HPS side as WORD_W-bit words over a valid/ready handshake, marking the last word. It replaces the fixed 4x4 combinational re-organiser and supports all sizes from 2 to MAX_DIM.

Parameters:
ELEM_W, 8, bits per matrix element
MAX_DIM, 5, maximum matrix dimension; the input holds MAX_DIM rows of MAX_DIM elements
WORD_W, 32, HPS transfer word width
TOTAL_W, MAX_DIM*MAX_DIM*ELEM_W (200), input and packed vector width (derived, not overridable)
NWORDS_MAX, ceil(TOTAL_W/WORD_W) (7), maximum words per transfer (derived)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  result matrix present on matrix_in
in_ready  out  1  block can accept a matrix
matrix_in  in  TOTAL_W  padded result; element (r,c) at bits [TOTAL_W-1-(r*MAX_DIM+c)*ELEM_W -: ELEM_W]
size_in  in  $clog2(MAX_DIM+1)  active dimension N, sampled with matrix_in
out_valid  out  1  word_out valid
out_ready  in  1  HPS side accepts word
word_out  out  WORD_W  current packed word
out_last  out  1  word_out is the final word of the matrix
word_count  out  $clog2(NWORDS_MAX+1)  words in the current transfer
packed_out  out  TOTAL_W  dense vector; element (r,c) at bits [TOTAL_W-1-(r*N+c)*ELEM_W -: ELEM_W], remaining bits zero
size_err  out  1  one-cycle pulse when a matrix with illegal size is rejected

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, in_ready=1, out_valid=0, out_last=0, word_out=0, word_count=0, packed_out=0, size_err=0. Reset mid-transfer abandons the transfer; no further words are issued.
- FSM states: IDLE, PACK, SEND.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - If 2<=size_in<=MAX_DIM: register matrix_in and size_in, go to PACK.
  - Otherwise: pulse size_err for 1 cycle, stay in IDLE, and leave packed_out and word_count unchanged.
- PACK (1 cycle): in_ready=0. Compute and register packed_out. Set word_count = ceil(N*N*ELEM_W/WORD_W), giving 1/3/4/7 for N=2/3/4/5 at the default parameters. Clear the word index. Go to SEND.
- SEND: in_ready=0 and out_valid=1.
  - word_out = word k of {packed_out, zero pad to NWORDS_MAX*WORD_W}, taken MSB-first: bits [NWORDS_MAX*WORD_W-1-k*WORD_W -: WORD_W].
  - out_last=1 when k==word_count-1.
  - On out_valid&&out_ready, k increments. If out_last is set, go to IDLE with out_valid=0 on the next cycle.
  - word_out, out_last and out_valid are held stable while out_ready=0.
- Latency: capture handshake at edge T produces the first out_valid at edge T+2. With out_ready held at 1, one word is sent per cycle. The next capture is accepted one cycle after the last word is accepted.
- packed_out holds its value after SEND until the next legal capture, so the HPS can also read it in parallel.
- All outputs are registered; no combinational path from inputs to outputs except in_ready (state decode only).
- Padding bits, elements with r>=N or c>=N, and bits of the final partial word are always zero.

Decomposition:
- Package buffer_pkg: ELEM_W, MAX_DIM and WORD_W defaults; the derived TOTAL_W/NWORDS_MAX; the state encoding (IDLE=0, PACK=1, SEND=2); MIN_DIM=2.
- Sub-module matrix_nxn_pack: purely combinational repack of matrix_in to packed_out for a given N, built as a generate loop over (r,c) with an N-dependent select. The FSM, word counter and handshake live in the top module.

Test Plan:
In the stimulus below, matrix_in element (r,c) = {r[3:0],c[3:0]} for all r,c<5.
- N=4, out_ready=1 -> 4 words 00010203, 10111213, 20212223, 30313233. out_last on word 3; packed_out[71:0]=0; first out_valid 2 cycles after capture.
- N=5 -> 7 words 00010203, 04101112, 13142021, 22232430, 31323334, 40414243, 44000000; out_last on word 6.
- N=3 with out_ready toggling 1,0,0,1,... -> words 00010210, 11122021, 22000000. Each word is held stable while stalled, and no word is duplicated or skipped.
- N=2 -> single word 00011011 with out_valid and out_last together; in_ready returns high the cycle after acceptance.
- size_in=1, then size_in=6 -> size_err pulses twice, out_valid stays 0, packed_out is unchanged. in_valid while in SEND -> in_ready=0 and the capture is ignored.
- rst_n=0 during word 2 of an N=5 transfer -> the next cycle shows out_valid=0, in_ready=1, packed_out=0; a new N=2 capture then streams correctly.
